// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
//   we    : one-cycle write strobe per assembled word
//   addr  : word address of the write
//   wdata : 32-bit little-endian assembled word
// master = loader (drives), slave = instruction memory (receives).
interface imem_uart_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// Serial boot loader: receives 8N1 UART bytes, validates a frame header
// (HDR_BYTE, 16-bit little-endian word count, then data), assembles
// little-endian 32-bit words and writes one per word into instruction memory.
// Holds the core pipeline in reset until a frame completes.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   rx         : UART serial input, idle high, asynchronous to clk
//   imem       : instruction-memory write port (we / addr / wdata)
//   core_hold  : 1 = hold pipeline in reset
//   busy       : header accepted, frame not yet complete
//   done       : last frame completed without overflow
//   err_frame  : sticky, a stop bit was sampled low
//   err_ovf    : sticky, word count exceeded memory depth
module imem_uart_loader #(
  parameter int unsigned CLKS_PER_BIT  = 868,
  parameter int unsigned ADDR_W        = 10,
  parameter logic [7:0]  HDR_BYTE      = 8'hA5,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  imem_uart_loader_if.master  imem,
  output logic                core_hold,
  output logic                busy,
  output logic                done,
  output logic                err_frame,
  output logic                err_ovf
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 17;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_t;
  typedef enum logic [2:0] {F_IDLE, F_CNT_LO, F_CNT_HI, F_DATA, F_DONE} frame_state_t;

  // Two-flop synchronizer plus previous value for start-edge detection.
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_t        r_state, r_state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bitn, bitn_d;
  logic [7:0]       shreg, shreg_d;
  logic             byte_valid, byte_valid_d;
  logic             stop_err, stop_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= R_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      r_state    <= r_state_d;
      cnt        <= cnt_d;
      bitn       <= bitn_d;
      shreg      <= shreg_d;
      byte_valid <= byte_valid_d;
      stop_err   <= stop_err_d;
    end
  end

  always_comb begin
    r_state_d    = r_state;
    cnt_d        = cnt + CNT_W'(1);
    bitn_d       = bitn;
    shreg_d      = shreg;
    byte_valid_d = 1'b0;
    stop_err_d   = 1'b0;
    case (r_state)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) r_state_d = R_START;
      end
      R_START: begin
        // Mid-start-bit re-check rejects short glitches.
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_d  = '0;
          bitn_d = '0;
          r_state_d = rx_sync ? R_IDLE : R_BITS;
        end
      end
      R_BITS: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_sync, shreg[7:1]};
          bitn_d  = bitn + 3'd1;
          if (bitn == 3'd7) r_state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          r_state_d = R_IDLE;
          if (rx_sync) byte_valid_d = 1'b1;
          else         stop_err_d   = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------- Frame FSM ----------------
  frame_state_t      f_state, f_state_d;
  logic [15:0]       count, count_d;
  logic [IDX_W-1:0]  idx, idx_d, idx_inc;
  logic [1:0]        lane, lane_d;
  logic [23:0]       wbuf, wbuf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_d, busy_d, done_d, ferr_d, ovf_d;

  assign imem.we    = we_q;
  assign imem.addr  = addr_q;
  assign imem.wdata = wdata_q;
  assign idx_inc    = idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_state   <= F_IDLE;
      count     <= '0;
      idx       <= '0;
      lane      <= '0;
      wbuf      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      core_hold <= HOLD_AT_RESET;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      f_state   <= f_state_d;
      count     <= count_d;
      idx       <= idx_d;
      lane      <= lane_d;
      wbuf      <= wbuf_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      core_hold <= hold_d;
      busy      <= busy_d;
      done      <= done_d;
      err_frame <= ferr_d;
      err_ovf   <= ovf_d;
    end
  end

  always_comb begin
    f_state_d = f_state;
    count_d   = count;
    idx_d     = idx;
    lane_d    = lane;
    wbuf_d    = wbuf;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hold_d    = core_hold;
    busy_d    = busy;
    done_d    = done;
    ferr_d    = err_frame;
    ovf_d     = err_ovf;
    case (f_state)
      F_IDLE, F_DONE: begin
        if (byte_valid && shreg == HDR_BYTE) begin
          hold_d    = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          ferr_d    = 1'b0;
          ovf_d     = 1'b0;
          idx_d     = '0;
          lane_d    = '0;
          f_state_d = F_CNT_LO;
        end
      end
      F_CNT_LO: begin
        if (byte_valid) begin
          count_d[7:0] = shreg;
          f_state_d    = F_CNT_HI;
        end
      end
      F_CNT_HI: begin
        if (byte_valid) begin
          count_d[15:8] = shreg;
          if ({shreg, count[7:0]} == 16'd0) begin
            f_state_d = F_DONE;
            busy_d    = 1'b0;
            hold_d    = 1'b0;
            done_d    = !err_ovf;
          end else begin
            f_state_d = F_DATA;
          end
        end
      end
      F_DATA: begin
        if (byte_valid) begin
          lane_d = lane + 2'd1;
          case (lane)
            2'd0: wbuf_d[7:0]   = shreg;
            2'd1: wbuf_d[15:8]  = shreg;
            2'd2: wbuf_d[23:16] = shreg;
            default: begin
              // Words past the memory depth are consumed but never written.
              if (idx >= IDX_W'(DEPTH)) begin
                ovf_d = 1'b1;
              end else begin
                we_d    = 1'b1;
                addr_d  = idx[ADDR_W-1:0];
                wdata_d = {shreg, wbuf};
              end
              idx_d = idx_inc;
              if (idx_inc == IDX_W'(count)) begin
                f_state_d = F_DONE;
                busy_d    = 1'b0;
                hold_d    = 1'b0;
                done_d    = !ovf_d;
              end
            end
          endcase
        end
      end
      default: f_state_d = F_IDLE;
    endcase
    // Framing errors never coincide with byte_valid, so header clear cannot race.
    if (stop_err) ferr_d = 1'b1;
  end

endmodule
